// File: rtl/nbr_pkg.sv
// Shared widths, codes and types for the neighbour-state frame transmitter.
package nbr_pkg;

  localparam int W                = 2;
  localparam int SLOTS            = 4;
  localparam logic [W-1:0] IDLE_CODE = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [1:0] slot_t;

endpackage

// File: rtl/nbr_next_slot.sv
// Finds the lowest present slot, either from slot 0 or strictly above cur.
module nbr_next_slot
  import nbr_pkg::*;
(
  input  logic [SLOTS-1:0] mask,
  input  slot_t            cur,
  input  logic             from_start,
  output slot_t            nxt,
  output logic             none
);

  // Scan downward so the lowest qualifying slot is the one left standing.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (mask[k] && (from_start || (slot_t'(k) > cur))) begin
        nxt  = slot_t'(k);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/nbr_frame_tx.sv
// Captures up to four neighbour states per load and streams the present ones
// out one slot per beat on a valid/ready bus.
module nbr_frame_tx
  import nbr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  output logic               load_ready,
  input  logic [SLOTS*W-1:0] nbr_in,
  input  logic [SLOTS-1:0]   nbr_mask,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [W-1:0]       tx_data,
  output logic [1:0]         tx_slot,
  output logic               tx_sof,
  output logic               tx_eof,
  output logic               frame_done,
  output logic               overrun
);

  state_t           state_q, state_d;
  logic [W-1:0]     data_q [SLOTS];
  logic [W-1:0]     data_d [SLOTS];
  logic [W-1:0]     nbr_arr [SLOTS];
  logic [SLOTS-1:0] mask_q, mask_d;
  slot_t            cur_q, cur_d;
  logic             sof_q, sof_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  slot_t            first_idx, next_idx;
  logic             first_none, last_none;
  logic             handshake, accept;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
    assign nbr_arr[gi] = nbr_in[gi*W +: W];
  end

  nbr_next_slot u_first (
    .mask       (nbr_mask),
    .cur        (2'd0),
    .from_start (1'b1),
    .nxt        (first_idx),
    .none       (first_none)
  );

  // Same finder on the captured mask gives both the advance target and eof.
  nbr_next_slot u_next (
    .mask       (mask_q),
    .cur        (cur_q),
    .from_start (1'b0),
    .nxt        (next_idx),
    .none       (last_none)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      cur_q     <= '0;
      sof_q     <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < SLOTS; k++) data_q[k] <= IDLE_CODE;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cur_q     <= cur_d;
      sof_q     <= sof_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      for (int k = 0; k < SLOTS; k++) data_q[k] <= data_d[k];
    end
  end

  assign handshake  = tx_valid & tx_ready;
  assign load_ready = (state_q == IDLE) | (handshake & tx_eof);
  assign accept     = load & load_ready;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    cur_d     = cur_q;
    sof_d     = sof_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (load & ~load_ready);
    if (handshake) begin
      if (tx_eof) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cur_d = next_idx;
        sof_d = 1'b0;
      end
    end
    // A load in the eof cycle overrides the return to IDLE.
    if (accept) begin
      data_d  = nbr_arr;
      mask_d  = nbr_mask;
      cur_d   = first_idx;
      sof_d   = 1'b1;
      state_d = first_none ? IDLE : SEND;
      if (first_none) done_d = 1'b1;
    end
  end

  always_comb begin
    tx_valid   = (state_q == SEND);
    tx_data    = tx_valid ? data_q[cur_q] : IDLE_CODE;
    tx_slot    = tx_valid ? cur_q : 2'd0;
    tx_sof     = tx_valid & sof_q;
    tx_eof     = tx_valid & last_none;
    frame_done = done_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_nbr_frame_tx.sv
// Directed scenarios plus a randomized run against a beat-queue reference model.
module tb_nbr_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       load_ready;
  logic [7:0] nbr_in;
  logic [3:0] nbr_mask;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] tx_data;
  logic [1:0] tx_slot;
  logic       tx_sof;
  logic       tx_eof;
  logic       frame_done;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [6:0] obs;
  assign obs = {tx_valid, tx_slot, tx_data, tx_sof, tx_eof};
  localparam logic [6:0] IDLE_OBS = 7'b0_00_11_0_0;

  typedef struct packed {
    logic [1:0] slot;
    logic [1:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  always #5 clk = ~clk;

  nbr_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_ready (load_ready),
    .nbr_in     (nbr_in),
    .nbr_mask   (nbr_mask),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_slot    (tx_slot),
    .tx_sof     (tx_sof),
    .tx_eof     (tx_eof),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; nbr_in = '0; nbr_mask = '0; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE_OBS) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, IDLE_OBS);
    end
    checks++;
    if ({frame_done, overrun, load_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_flags: got %b expected 001", {frame_done, overrun, load_ready});
    end
    $display("test_reset done");
  endtask

  task automatic test_full_mask();
    logic [6:0] exp;
    load = 1'b1; nbr_in = 8'b11_10_01_00; nbr_mask = 4'b1111; tx_ready = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL full_load_ready: got %b expected 1", load_ready);
    end
    tick();
    load = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp = {1'b1, 2'(b), 2'(b), (b == 0), (b == 3)};
      checks++;
      if (obs !== exp || frame_done !== 1'b0) begin
        errors++; $display("FAIL full_beat%0d: got %b done=%b expected %b done=0", b, obs, frame_done, exp);
      end
      $display("full_mask beat slot=%0d data=%b sof=%b eof=%b", tx_slot, tx_data, tx_sof, tx_eof);
      tick();
    end
    checks++;
    if (frame_done !== 1'b1 || obs !== IDLE_OBS) begin
      errors++; $display("FAIL full_done: got done=%b obs=%b expected done=1 obs=%b", frame_done, obs, IDLE_OBS);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL full_done_width: got %b expected 0", frame_done);
    end
  endtask

  task automatic test_sparse_backpressure();
    logic [7:0] d;
    d = 8'($urandom);
    load = 1'b1; nbr_in = d; nbr_mask = 4'b1010; tx_ready = 1'b0;
    tick();
    load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nbr_in = 8'($urandom);
      #1;
      checks++;
      if (obs !== {1'b1, 2'd1, d[3:2], 1'b1, 1'b0}) begin
        errors++; $display("FAIL sparse_hold%0d: got %b expected %b", c, obs, {1'b1, 2'd1, d[3:2], 2'b10});
      end
      $display("sparse stall cycle %0d slot=%0d data=%b", c, tx_slot, tx_data);
      tick();
    end
    tx_ready = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 2'd1, d[3:2], 1'b1, 1'b0}) begin
      errors++; $display("FAIL sparse_first: got %b expected %b", obs, {1'b1, 2'd1, d[3:2], 2'b10});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'd3, d[7:6], 1'b0, 1'b1}) begin
      errors++; $display("FAIL sparse_last: got %b expected %b", obs, {1'b1, 2'd3, d[7:6], 2'b01});
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL sparse_done: got done=%b valid=%b expected 1 0", frame_done, tx_valid);
    end
    tick();
  endtask

  task automatic test_empty_mask();
    load = 1'b1; nbr_in = 8'($urandom); nbr_mask = 4'b0000; tx_ready = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || obs !== IDLE_OBS) begin
      errors++; $display("FAIL empty_done: got done=%b obs=%b expected done=1 obs=%b", frame_done, obs, IDLE_OBS);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL empty_after: got done=%b valid=%b expected 0 0", frame_done, tx_valid);
    end
    $display("empty_mask load handled");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    load = 1'b1; nbr_in = a; nbr_mask = 4'b0011; tx_ready = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (obs !== {1'b1, 2'd0, a[1:0], 2'b10}) begin
      errors++; $display("FAIL b2b_a0: got %b expected %b", obs, {1'b1, 2'd0, a[1:0], 2'b10});
    end
    tick();
    load = 1'b1; nbr_in = b; nbr_mask = 4'b0110;
    #1;
    checks++;
    if (obs !== {1'b1, 2'd1, a[3:2], 2'b01} || load_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_a1: got %b ready=%b expected %b ready=1", obs, load_ready, {1'b1, 2'd1, a[3:2], 2'b01});
    end
    tick();
    load = 1'b0;
    checks++;
    if (obs !== {1'b1, 2'd1, b[3:2], 2'b10} || frame_done !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_b_sof: got %b done=%b ovr=%b expected %b done=1 ovr=0", obs, frame_done, overrun, {1'b1, 2'd1, b[3:2], 2'b10});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'd2, b[5:4], 2'b01} || frame_done !== 1'b0) begin
      errors++; $display("FAIL b2b_b_eof: got %b done=%b expected %b done=0", obs, frame_done, {1'b1, 2'd2, b[5:4], 2'b01});
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_done: got done=%b ovr=%b expected 1 0", frame_done, overrun);
    end
    $display("back_to_back frames A=%h B=%h", a, b);
    tick();
  endtask

  task automatic test_overrun();
    logic [7:0] a;
    a = 8'($urandom);
    load = 1'b1; nbr_in = a; nbr_mask = 4'b1101; tx_ready = 1'b0;
    tick();
    load = 1'b1; nbr_in = ~a; nbr_mask = 4'b0010;
    #1;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++; $display("FAIL ovr_ready: got %b expected 0", load_ready);
    end
    tick();
    load = 1'b0; tx_ready = 1'b1;
    #1;
    checks++;
    if (overrun !== 1'b1 || obs !== {1'b1, 2'd0, a[1:0], 2'b10}) begin
      errors++; $display("FAIL ovr_set: got ovr=%b obs=%b expected ovr=1 obs=%b", overrun, obs, {1'b1, 2'd0, a[1:0], 2'b10});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'd2, a[5:4], 2'b00}) begin
      errors++; $display("FAIL ovr_mid: got %b expected %b", obs, {1'b1, 2'd2, a[5:4], 2'b00});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'd3, a[7:6], 2'b01}) begin
      errors++; $display("FAIL ovr_last: got %b expected %b", obs, {1'b1, 2'd3, a[7:6], 2'b01});
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || overrun !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_end: got done=%b ovr=%b valid=%b expected 1 1 0", frame_done, overrun, tx_valid);
    end
    $display("overrun frame completed data=%h", a);
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] a;
    a = 8'($urandom);
    load = 1'b1; nbr_in = a; nbr_mask = 4'b1111; tx_ready = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== {1'b1, 2'd2, a[5:4], 2'b00}) begin
      errors++; $display("FAIL rstmid_beat2: got %b expected %b", obs, {1'b1, 2'd2, a[5:4], 2'b00});
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (obs !== IDLE_OBS || frame_done !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: got %b done=%b ovr=%b expected %b done=0 ovr=0", obs, frame_done, overrun, IDLE_OBS);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_nodone: got %b expected 0", frame_done);
    end
    a = 8'($urandom);
    load = 1'b1; nbr_in = a; nbr_mask = 4'b0101;
    tick();
    load = 1'b0;
    checks++;
    if (obs !== {1'b1, 2'd0, a[1:0], 2'b10}) begin
      errors++; $display("FAIL rstmid_new0: got %b expected %b", obs, {1'b1, 2'd0, a[1:0], 2'b10});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 2'd2, a[5:4], 2'b01}) begin
      errors++; $display("FAIL rstmid_new1: got %b expected %b", obs, {1'b1, 2'd2, a[5:4], 2'b01});
    end
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL rstmid_newdone: got %b expected 1", frame_done);
    end
    $display("reset_mid_frame recovered");
    tick();
  endtask

  // Reference model: a frame is just the ascending list of present slots.
  task automatic test_random();
    beat_t      q[$];
    beat_t      bt;
    bit         exp_done, exp_ovr, done_n, exp_ldr;
    logic [6:0] exp_obs;
    int         present[$];
    exp_done = 1'b0;
    exp_ovr  = 1'b0;
    for (int n = 0; n < 500; n++) begin
      load     = ($urandom_range(0, 2) == 0);
      nbr_in   = 8'($urandom);
      nbr_mask = 4'($urandom);
      tx_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_obs = (q.size() > 0) ? {1'b1, q[0].slot, q[0].data, q[0].sof, q[0].eof} : IDLE_OBS;
      exp_ldr = (q.size() == 0) || (tx_ready && q[0].eof);
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL rand_beat cyc %0d: got %b expected %b", n, obs, exp_obs);
      end
      checks++;
      if (load_ready !== exp_ldr) begin
        errors++; $display("FAIL rand_load_ready cyc %0d: got %b expected %b", n, load_ready, exp_ldr);
      end
      checks++;
      if (frame_done !== exp_done || overrun !== exp_ovr) begin
        errors++; $display("FAIL rand_flags cyc %0d: got done=%b ovr=%b expected done=%b ovr=%b", n, frame_done, overrun, exp_done, exp_ovr);
      end
      if (tx_valid && tx_ready)
        $display("rand beat cyc %0d slot=%0d data=%b sof=%b eof=%b", n, tx_slot, tx_data, tx_sof, tx_eof);
      done_n = 1'b0;
      if (q.size() > 0 && tx_ready) begin
        if (q[0].eof) done_n = 1'b1;
        void'(q.pop_front());
      end
      if (load) begin
        if (exp_ldr) begin
          present.delete();
          for (int k = 0; k < 4; k++) if (nbr_mask[k]) present.push_back(k);
          for (int i = 0; i < present.size(); i++) begin
            bt.slot = 2'(present[i]);
            bt.data = nbr_in[present[i]*2 +: 2];
            bt.sof  = (i == 0);
            bt.eof  = (i == present.size() - 1);
            q.push_back(bt);
          end
          if (present.size() == 0) done_n = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end
      exp_done = done_n;
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_backpressure();
    test_empty_mask();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
